// File: rtl/decode_stage.sv
// RV32 ID stage: decodes the IF/ID instruction, reads and bypasses operands, builds the
// immediate, detects load-use hazards and holds the ID/EX pipeline register.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              ValidD,
    input  logic [XLEN-1:0]   RD1,
    input  logic [XLEN-1:0]   RD2,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              StallE,
    input  logic              FlushE,
    output logic [REG_AW-1:0] A1,
    output logic [REG_AW-1:0] A2,
    output logic              StallD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              BranchE,
    output logic              JumpE,
    output logic              IllegalE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic              illegal;
        logic [1:0]        result_src;
        logic [2:0]        alu_ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } idex_t;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic [2:0]        w_alu_funct;
    logic              w_funct3_ok;
    logic              w_reg_write, w_mem_write, w_alu_src, w_branch, w_jump;
    logic              w_illegal, w_uses_rs2;
    logic [1:0]        w_result_src;
    logic [2:0]        w_alu_ctrl;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_rd1, w_rd2;
    logic              w_haz;
    idex_t             w_next;
    idex_t             r_idex;

    assign w_opcode = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_rs1    = InstrD[19:15];
    assign w_rs2    = InstrD[24:20];
    assign w_rd     = InstrD[11:7];
    assign A1       = w_rs1;
    assign A2       = w_rs2;

    assign w_imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    assign w_imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign w_imm_b = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // funct7[5] selects sub only for R-type; I-ALU funct3=000 is always addi.
    always_comb begin
        w_funct3_ok = 1'b1;
        w_alu_funct = ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_funct = (w_opcode == OP_RTYPE && InstrD[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_funct = ALU_SLT;
            3'b110:  w_alu_funct = ALU_OR;
            3'b111:  w_alu_funct = ALU_AND;
            default: w_funct3_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_illegal    = 1'b0;
        w_uses_rs2   = 1'b0;
        w_result_src = RES_ALU;
        w_alu_ctrl   = ALU_ADD;
        w_imm        = '0;
        case (w_opcode)
            OP_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    w_reg_write  = 1'b1;
                    w_alu_src    = 1'b1;
                    w_result_src = RES_MEM;
                    w_imm        = w_imm_i;
                end else w_illegal = 1'b1;
            end
            OP_STORE: begin
                w_uses_rs2 = 1'b1;
                if (w_funct3 == 3'b010) begin
                    w_mem_write = 1'b1;
                    w_alu_src   = 1'b1;
                    w_imm       = w_imm_s;
                end else w_illegal = 1'b1;
            end
            OP_RTYPE: begin
                w_uses_rs2 = 1'b1;
                if (w_funct3_ok) begin
                    w_reg_write = 1'b1;
                    w_alu_ctrl  = w_alu_funct;
                end else w_illegal = 1'b1;
            end
            OP_IALU: begin
                if (w_funct3_ok) begin
                    w_reg_write = 1'b1;
                    w_alu_src   = 1'b1;
                    w_alu_ctrl  = w_alu_funct;
                    w_imm       = w_imm_i;
                end else w_illegal = 1'b1;
            end
            OP_BRANCH: begin
                w_uses_rs2 = 1'b1;
                if (w_funct3 == 3'b000) begin
                    w_branch   = 1'b1;
                    w_alu_ctrl = ALU_SUB;
                    w_imm      = w_imm_b;
                end else w_illegal = 1'b1;
            end
            OP_JAL: begin
                w_jump       = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = RES_PC4;
                w_imm        = w_imm_j;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // The register file writes on the same edge we sample, so forward ResultW here.
    assign w_rd1 = (w_rs1 == '0) ? '0 : (RegWriteW && RdW == w_rs1) ? ResultW : RD1;
    assign w_rd2 = (w_rs2 == '0) ? '0 : (RegWriteW && RdW == w_rs2) ? ResultW : RD2;

    always_comb begin
        w_next       = '0;
        w_next.valid = ValidD;
        if (ValidD) begin
            w_next.reg_write  = w_reg_write;
            w_next.mem_write  = w_mem_write;
            w_next.alu_src    = w_alu_src;
            w_next.branch     = w_branch;
            w_next.jump       = w_jump;
            w_next.illegal    = w_illegal;
            w_next.result_src = w_result_src;
            w_next.alu_ctrl   = w_alu_ctrl;
        end
        w_next.rd1      = w_rd1;
        w_next.rd2      = w_rd2;
        w_next.imm      = w_imm;
        w_next.pc       = PCD;
        w_next.pc_plus4 = PCPlus4D;
        w_next.rs1      = w_rs1;
        w_next.rs2      = w_rs2;
        w_next.rd       = w_rd;
    end

    assign w_haz = r_idex.valid && (r_idex.result_src == RES_MEM) && (r_idex.rd != '0) && ValidD &&
                   ((r_idex.rd == w_rs1) || ((r_idex.rd == w_rs2) && w_uses_rs2));
    assign StallD = w_haz | StallE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idex <= '0;
        end else if (FlushE || (!StallE && w_haz)) begin
            r_idex <= '0;
        end else if (!StallE) begin
            r_idex <= w_next;
        end
    end

    assign ValidE      = r_idex.valid;
    assign RegWriteE   = r_idex.reg_write;
    assign MemWriteE   = r_idex.mem_write;
    assign ALUSrcE     = r_idex.alu_src;
    assign BranchE     = r_idex.branch;
    assign JumpE       = r_idex.jump;
    assign IllegalE    = r_idex.illegal;
    assign ResultSrcE  = r_idex.result_src;
    assign ALUControlE = r_idex.alu_ctrl;
    assign RD1E        = r_idex.rd1;
    assign RD2E        = r_idex.rd2;
    assign ImmExtE     = r_idex.imm;
    assign PCE         = r_idex.pc;
    assign PCPlus4E    = r_idex.pc_plus4;
    assign Rs1E        = r_idex.rs1;
    assign Rs2E        = r_idex.rs2;
    assign RdE         = r_idex.rd;

endmodule
